// File: rtl/n_reg_file.sv
// -----------------------------------------------------------------------------
// n_reg_file
//
// Multi-read-port general-purpose register file for one core's decode stage.
// DEPTH words of WIDTH bits, each held in its own enabled register, with one
// synchronous write port and NUM_RD independent combinational read ports.
//
// Parameters:
//   WIDTH    - bits per entry
//   DEPTH    - number of entries (>= 2); ADDR_W = $clog2(DEPTH)
//   NUM_RD   - number of read ports (>= 1)
//   ZERO_REG - nonzero: entry 0 always reads 0 and ignores writes
//   BYPASS   - nonzero: a read of the address being written this cycle returns
//              wdata (write-first); zero: returns the stored value (read-first)
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset; clears every entry and wr_err
//   we       in   write enable
//   waddr    in   [ADDR_W]        write address
//   wdata    in   [WIDTH]         write data
//   raddr    in   [NUM_RD*ADDR_W] read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata    out  [NUM_RD*WIDTH]  read data, port i at [i*WIDTH +: WIDTH]
//   wr_err   out  registered; high for one cycle after a write to waddr >= DEPTH
// -----------------------------------------------------------------------------
module n_reg_file #(
    parameter int  WIDTH    = 32,
    parameter int  DEPTH    = 32,
    parameter int  NUM_RD   = 2,
    parameter int  ZERO_REG = 1,
    parameter int  BYPASS   = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*WIDTH-1:0]  rdata,
    output logic                     wr_err
);

    // DEPTH held one bit wider than an address so the range test also works
    // when DEPTH is an exact power of two.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_EXT);
    endfunction

    // A write only "fires" when it really lands in storage. The same signal
    // gates the bypass path, so a write suppressed by the zero-register or
    // out-of-range rules is never bypassed, and nothing bypasses in reset.
    logic wr_zero;
    logic wr_fire;

    assign wr_zero = (ZERO_REG != 0) && (waddr == '0);
    assign wr_fire = reset_n && we && in_range(waddr) && !wr_zero;

    // -------------------------------------------------------------------------
    // Storage: one enabled register per entry
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] word_q [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign word_q[i] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    q <= '0;
                end else if (wr_fire && (waddr == ADDR_W'(i))) begin
                    q <= wdata;
                end
            end

            assign word_q[i] = q;
        end
    end

    // -------------------------------------------------------------------------
    // Out-of-range write flag: reflects only the most recent edge
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= we && !in_range(waddr);
        end
    end

    // -------------------------------------------------------------------------
    // Read ports: purely combinational, each independent of the others
    // -------------------------------------------------------------------------
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  val;

        assign ra = raddr[p*ADDR_W +: ADDR_W];

        always_comb begin
            val = '0;
            if ((ZERO_REG != 0) && (ra == '0)) begin
                val = '0;
            end else if (!in_range(ra)) begin
                val = '0;
            end else if ((BYPASS != 0) && wr_fire && (ra == waddr)) begin
                val = wdata;
            end else begin
                // Explicit compare-select keeps addresses >= DEPTH from ever
                // indexing past the end of the array.
                for (int j = 0; j < DEPTH; j++) begin
                    if (ra == ADDR_W'(j)) begin
                        val = word_q[j];
                    end
                end
            end
        end

        assign rdata[p*WIDTH +: WIDTH] = val;
    end

endmodule

// File: tb/tb_n_reg_file.sv
// -----------------------------------------------------------------------------
// tb_n_reg_file
//
// Two register files driven by the same stimulus:
//   dut_a : DEPTH=32, NUM_RD=4, ZERO_REG=1, BYPASS=1 (write-first)
//   dut_b : DEPTH=24, NUM_RD=4, ZERO_REG=0, BYPASS=0 (read-first, has
//           out-of-range addresses 24..31)
// A behavioural model (plain arrays) predicts every read port and wr_err; the
// compare process checks all of them on every falling edge, and also drains
// a queue of hand-computed literal expectations pushed by the driver.
// -----------------------------------------------------------------------------
module tb_n_reg_file;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          we      = 1'b0;
    logic [AW-1:0] waddr   = '0;
    logic [W-1:0]  wdata   = '0;
    logic [NR*AW-1:0] raddr = '0;

    logic [NR*W-1:0] rdata_a;
    logic [NR*W-1:0] rdata_b;
    logic            wr_err_a;
    logic            wr_err_b;

    always #5 clk = ~clk;

    n_reg_file #(
        .WIDTH(W), .DEPTH(32), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_a), .wr_err(wr_err_a)
    );

    n_reg_file #(
        .WIDTH(W), .DEPTH(24), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .wr_err(wr_err_b)
    );

    // -------------------------------------------------------------------------
    // Behavioural model (config 0 = dut_a, config 1 = dut_b)
    // -------------------------------------------------------------------------
    logic [W-1:0] mem_a [32];
    logic [W-1:0] mem_b [32];
    logic         err_a = 1'b0;
    logic         err_b = 1'b0;

    function automatic int depth_of(input int c);
        return (c == 0) ? 32 : 24;
    endfunction

    // Does the current write really change storage in configuration c?
    function automatic bit wr_ok(input int c);
        int wa;
        wa = int'(waddr);
        if (!reset_n || !we)         return 1'b0;
        if (wa >= depth_of(c))       return 1'b0;
        if ((c == 0) && (wa == 0))   return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] model_rd(input int c, input int a);
        if ((c == 0) && (a == 0))    return '0;
        if (a >= depth_of(c))        return '0;
        if (!reset_n)                return '0;
        if ((c == 0) && wr_ok(0) && (int'(waddr) == a)) return wdata;
        return (c == 0) ? mem_a[a] : mem_b[a];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                mem_a[i] = '0;
                mem_b[i] = '0;
            end
            err_a = 1'b0;
            err_b = 1'b0;
        end else begin
            err_a = we && (int'(waddr) >= depth_of(0));
            err_b = we && (int'(waddr) >= depth_of(1));
            if (wr_ok(0)) mem_a[waddr] = wdata;
            if (wr_ok(1)) mem_b[waddr] = wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int           sel_q[$];
    int           n_cmp  = 0;
    int           n_bad  = 0;
    logic         chk_en = 1'b0;

    // sel 0..3: dut_a port, 4..7: dut_b port, 8: wr_err_a, 9: wr_err_b
    function automatic logic [W-1:0] pick(input int sel);
        if (sel < 4)  return rdata_a[sel*W +: W];
        if (sel < 8)  return rdata_b[(sel-4)*W +: W];
        if (sel == 8) return {{(W-1){1'b0}}, wr_err_a};
        return {{(W-1){1'b0}}, wr_err_b};
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, e);
        end
    endtask

    always @(negedge clk) begin
        int sel;
        logic [W-1:0] e;
        if (chk_en) begin
            for (int p = 0; p < NR; p++) begin
                int a;
                a = int'(raddr[p*AW +: AW]);
                check($sformatf("a.rdata%0d addr %0d", p, a), rdata_a[p*W +: W], model_rd(0, a));
                check($sformatf("b.rdata%0d addr %0d", p, a), rdata_b[p*W +: W], model_rd(1, a));
            end
            check("a.wr_err", {{(W-1){1'b0}}, wr_err_a}, {{(W-1){1'b0}}, err_a});
            check("b.wr_err", {{(W-1){1'b0}}, wr_err_b}, {{(W-1){1'b0}}, err_b});
        end
        while (exp_q.size() > 0) begin
            sel = sel_q.pop_front();
            e   = exp_q.pop_front();
            check($sformatf("literal sel%0d", sel), pick(sel), e);
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2, input logic [AW-1:0] r3);
        @(posedge clk);
        #1;
        we    = w;
        waddr = wa;
        wdata = wd;
        raddr = {r3, r2, r1, r0};
    endtask

    // Literal expectation checked at the falling edge of the current cycle.
    task automatic expect_lit(input int sel, input logic [W-1:0] v);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        // Reset state
        drive(0, 0, 0, 5, 5, 5, 5);
        expect_lit(0, 32'h0);
        expect_lit(8, 32'h0);
        expect_lit(9, 32'h0);

        // Write r5, then a mid-cycle reset must clear every port before the edge
        drive(1, 5, 32'hDEADBEEF, 5, 5, 5, 5);
        expect_lit(0, 32'hDEADBEEF);
        expect_lit(4, 32'h0);
        drive(0, 0, 0, 5, 5, 5, 5);
        expect_lit(0, 32'hDEADBEEF);
        expect_lit(4, 32'hDEADBEEF);
        drive(0, 0, 0, 5, 5, 5, 5);
        #2 reset_n = 1'b0;
        for (int s = 0; s < 8; s++) expect_lit(s, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive(0, 0, 0, 5, 5, 5, 5);
        expect_lit(0, 32'h0);
        expect_lit(4, 32'h0);

        // Basic write/read on consecutive cycles; r31 is out of range for dut_b
        drive(1, 7,  32'h12345678, 0, 0, 0, 0);
        drive(1, 31, 32'hCAFEF00D, 0, 0, 0, 0);
        drive(0, 0, 0, 7, 31, 7, 7);
        expect_lit(0, 32'h12345678);
        expect_lit(1, 32'hCAFEF00D);
        expect_lit(4, 32'h12345678);
        expect_lit(5, 32'h0);
        expect_lit(9, 32'h1);
        drive(0, 0, 0, 7, 7, 0, 0);
        expect_lit(0, 32'h12345678);
        expect_lit(1, 32'h12345678);
        expect_lit(9, 32'h0);

        // Zero register
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        expect_lit(0, 32'h0);
        expect_lit(4, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_lit(0, 32'h0);
        expect_lit(4, 32'hFFFFFFFF);

        // Bypass vs read-first
        drive(1, 3, 32'h11, 0, 0, 0, 0);
        drive(1, 3, 32'h22, 3, 3, 3, 3);
        expect_lit(0, 32'h22);
        expect_lit(4, 32'h11);
        drive(0, 0, 0, 3, 3, 3, 3);
        expect_lit(0, 32'h22);
        expect_lit(4, 32'h22);

        // Out-of-range write on dut_b (DEPTH=24); address 25 is legal on dut_a
        drive(1, 1, 32'h55, 0, 0, 0, 0);
        drive(1, 25, 32'hAB, 25, 1, 0, 0);
        expect_lit(0, 32'hAB);
        expect_lit(4, 32'h0);
        drive(0, 0, 0, 25, 1, 0, 0);
        expect_lit(9, 32'h1);
        expect_lit(8, 32'h0);
        expect_lit(4, 32'h0);
        expect_lit(5, 32'h55);
        expect_lit(0, 32'hAB);
        drive(0, 0, 0, 25, 1, 0, 0);
        expect_lit(9, 32'h0);
        expect_lit(5, 32'h55);

        // Back-to-back writes to one address: last wins
        drive(1, 9, 32'hA, 0, 0, 0, 0);
        drive(1, 9, 32'hB, 0, 0, 0, 0);
        drive(0, 0, 0, 9, 0, 0, 0);
        expect_lit(0, 32'hB);
        expect_lit(4, 32'hB);

        // Random soak with occasional mid-cycle reset
        for (int i = 0; i < 10000; i++) begin
            logic [NR*AW-1:0] ra;
            @(posedge clk);
            #1;
            if (!reset_n) reset_n = 1'b1;
            we    = ($urandom_range(0, 1) == 1);
            waddr = AW'($urandom_range(0, 31));
            wdata = $urandom;
            for (int p = 0; p < NR; p++) begin
                if ($urandom_range(0, 3) == 0) ra[p*AW +: AW] = waddr;
                else                           ra[p*AW +: AW] = AW'($urandom_range(0, 31));
            end
            raddr = ra;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_n = 1'b0;
            end
        end

        @(posedge clk);
        #1 we = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
